// File: rtl/regfile_if.sv
// Register-file access bundle: one write-back port and two decode-stage read ports.
// master drives the requests, slave (the register file) returns the read data.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;

  modport master (
    output we_i, waddr_i, wdata_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o
  );
endinterface

// File: rtl/regfile.sv
// 2**ADDR_W x DATA_W register file: one write port, two combinational read ports, x0 hard-wired to 0.
// Define RF_WB_BYPASS_EN to forward same-cycle write data onto a matching read port.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] entry_q [NREG];

  // Entry 0 is never written, so after reset it stays 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        entry_q[i] <= '0;
      end
    end else if (bus.we_i && (bus.waddr_i != '0)) begin
      entry_q[bus.waddr_i] <= bus.wdata_i;
    end
  end

  logic [1:0]        re;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign re        = {bus.re2_i, bus.re1_i};
  assign raddr[0]  = bus.raddr1_i;
  assign raddr[1]  = bus.raddr2_i;
  assign bus.rdata1_o = rdata[0];
  assign bus.rdata2_o = rdata[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic              hit;
      logic [DATA_W-1:0] rd;

`ifdef RF_WB_BYPASS_EN
      assign hit = bus.we_i && (bus.waddr_i == raddr[gi]);
`else
      assign hit = 1'b0;
`endif

      // Address 0 short-circuits before the bypass, so x0 is never forwarded.
      always_comb begin
        rd = '0;
        if (rst && re[gi] && (raddr[gi] != '0)) begin
          rd = hit ? bus.wdata_i : entry_q[raddr[gi]];
        end
      end

      assign rdata[gi] = rd;
    end
  endgenerate
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, reset corner sequences,
// and randomized dual-port traffic against an array-based reference model.
module tb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW)) rif ();

  regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  logic [DW-1:0] model [32];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re1;
    logic [AW-1:0] ra1;
    logic          re2;
    logic [AW-1:0] ra2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference read: what the architectural register state says a port must show.
  function automatic logic [DW-1:0] ref_rd(input logic re, input logic [AW-1:0] a);
    if (!rst || !re || a == 0) return '0;
    if (BYP && rif.we_i && rif.waddr_i == a) return rif.wdata_i;
    return model[a];
  endfunction

  task automatic drv(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic r1, input logic [AW-1:0] a1, input logic r2, input logic [AW-1:0] a2);
    rst          = r;
    rif.we_i     = we;
    rif.waddr_i  = wa;
    rif.wdata_i  = wd;
    rif.re1_i    = r1;
    rif.raddr1_i = a1;
    rif.re2_i    = r2;
    rif.raddr2_i = a2;
  endtask

  // One clock: compare mid-cycle, then commit the edge into the model.
  task automatic cyc(input string tag, input bit use_exp, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    logic [DW-1:0] x1, x2;
    #2;
    x1 = use_exp ? e1 : ref_rd(rif.re1_i, rif.raddr1_i);
    x2 = use_exp ? e2 : ref_rd(rif.re2_i, rif.raddr2_i);
    check({tag, ".p1"}, rif.rdata1_o, x1);
    check({tag, ".p2"}, rif.rdata2_o, x2);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (rif.we_i && rif.waddr_i != 0) begin
      model[rif.waddr_i] = rif.wdata_i;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    //              we  wa   wd              re1 ra1 re2 ra2 e1                                e2
    tbl[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd3,  1'b0, 5'd0,  32'h0, 32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd3,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  1'b1, 5'd3,  32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
    tbl[5] = '{1'b1, 5'd7,  32'h11111111, 1'b0, 5'd7,  1'b0, 5'd7,  32'h0, 32'h0};
    tbl[6] = '{1'b1, 5'd7,  32'h22222222, 1'b1, 5'd7,  1'b1, 5'd7,
               BYP ? 32'h22222222 : 32'h11111111, BYP ? 32'h22222222 : 32'h11111111};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'h22222222, 32'h22222222};
    tbl[8] = '{1'b1, 5'd31, 32'h80000001, 1'b1, 5'd31, 1'b1, 5'd3,
               BYP ? 32'h80000001 : 32'h0, 32'hDEADBEEF};
    tbl[9] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd31, 32'h80000001, 32'h80000001};

    drv(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    #1 rst = 1'b0;

    // Held in reset: every address on both ports reads 0, writes are ignored.
    for (int a = 0; a < 32; a++) begin
      drv(1'b0, 1'b1, AW'(a), $urandom, 1'b1, AW'(a), 1'b1, AW'(31 - a));
      #1;
      check("rst_hold.p1", rif.rdata1_o, '0);
      check("rst_hold.p2", rif.rdata2_o, '0);
    end
    $display("reset hold sweep done");
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int a = 0; a < 32; a++) begin
      drv(1'b1, 1'b0, '0, '0, 1'b1, AW'(a), 1'b1, AW'(31 - a));
      cyc("post_rst", 1'b0, '0, '0);
      $display("post-reset read x%0d / x%0d -> %h %h", a, 31 - a, rif.rdata1_o, rif.rdata2_o);
    end

    for (int v = 0; v < 10; v++) begin
      drv(1'b1, tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].re1, tbl[v].ra1, tbl[v].re2, tbl[v].ra2);
      cyc($sformatf("vec%0d", v), 1'b1, tbl[v].e1, tbl[v].e2);
      $display("vec%0d we=%b wa=%0d wd=%h ra1=%0d ra2=%0d -> %h %h",
               v, tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].ra1, tbl[v].ra2, rif.rdata1_o, rif.rdata2_o);
    end

    // Reset mid-operation, write ignored during reset, write taken in the release cycle.
    drv(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, '0, 1'b0, '0);
    cyc("wr_x9", 1'b0, '0, '0);
    drv(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 1'b1, 5'd9);
    #1;
    check("x9_before_rst", rif.rdata1_o, 32'hA5A5A5A5);
    #1 rst = 1'b0;
    #1;
    check("async_clr.p1", rif.rdata1_o, '0);
    check("async_clr.p2", rif.rdata2_o, '0);
    $display("async reset mid-cycle -> %h %h", rif.rdata1_o, rif.rdata2_o);
    drv(1'b0, 1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 1'b1, 5'd9);
    cyc("wr_in_rst", 1'b0, '0, '0);
    drv(1'b1, 1'b1, 5'd10, 32'hCAFEF00D, 1'b1, 5'd9, 1'b1, 5'd10);
    cyc("release_wr", 1'b0, '0, '0);
    drv(1'b1, 1'b0, '0, '0, 1'b1, 5'd10, 1'b1, 5'd9);
    #1;
    check("release_x10", rif.rdata1_o, 32'hCAFEF00D);
    check("cleared_x9", rif.rdata2_o, '0);
    #1;
    cyc("after_release", 1'b0, '0, '0);
    $display("after release x10=%h x9=%h", rif.rdata1_o, rif.rdata2_o);

    for (int c = 0; c < 10000; c++) begin
      logic          we;
      logic [AW-1:0] wa, a1, a2;
      we = $urandom_range(0, 1) == 1;
      wa = AW'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      drv($urandom_range(0, 299) != 0, we, wa, $urandom,
          $urandom_range(0, 3) != 0, a1, $urandom_range(0, 3) != 0, a2);
      if (!we && $urandom_range(0, 3) == 0) begin
        rif.waddr_i = 'x;
        rif.wdata_i = 'x;
      end
      cyc("rand", 1'b0, '0, '0);
    end
    $display("random phase: 10000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width; the entry count is 2**ADDR_W = 32.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low (asserted at 0).
REQ-005 we_i  input  1  SHALL be the write enable from write-back.
REQ-006 waddr_i  input  ADDR_W  SHALL be the write register address.
REQ-007 wdata_i  input  DATA_W  SHALL be the write data.
REQ-008 re1_i  input  1  SHALL be the read enable for port 1, driven by the decode stage.
REQ-009 raddr1_i  input  ADDR_W  SHALL be the read address for port 1.
REQ-010 rdata1_o  output  DATA_W  SHALL be the read data for port 1.
REQ-011 re2_i, raddr2_i, rdata2_o SHALL be identical to port 1 in direction and width, for port 2.

Function
REQ-012 Storage SHALL be 32 x DATA_W registers, x0..x31.
REQ-013 Write: at a rising clk with rst=1, we_i=1 and waddr_i!=0, entry[waddr_i] SHALL take wdata_i.
REQ-014 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-015 Reads SHALL be combinational (0-cycle latency) and independent per port.
REQ-016 For each port, rdata SHALL be 0 when rst=0, re=0, or raddr=0.
REQ-017 Otherwise rdata SHALL be entry[raddr], subject to the bypass rule in REQ-022.
REQ-018 Both ports reading the same address SHALL return identical data.
REQ-019 A write SHALL become visible through storage on the cycle after the write edge.
REQ-020 An X or undriven value on waddr_i or wdata_i while we_i=0 SHALL NOT alter storage.

Reset
REQ-021 While rst=0, all 32 entries SHALL clear to 0 asynchronously, no write SHALL occur, and both rdata outputs SHALL be 0. The first write SHALL be taken at the first rising clk after rst returns to 1; a write request in the deassertion cycle SHALL be taken at that edge.

Configuration
REQ-022 With macro RF_WB_BYPASS_EN defined: when we_i=1, waddr_i!=0, re=1 and raddr==waddr_i in the same cycle, rdata SHALL equal wdata_i (write-through), on either port or both.
REQ-023 Without RF_WB_BYPASS_EN: in that same-cycle case rdata SHALL return the old entry value. The new value SHALL appear the following cycle.
REQ-024 x0 SHALL never be bypassed in either configuration.

Verification
REQ-025 Reset then read: hold rst=0, set re1=1 and raddr1=5, then release rst -> rdata1_o=0x00000000. Repeat for raddr in 0..31 and both ports -> all zero.
REQ-026 Write then read: write x3=0xDEADBEEF; next cycle set re1=1, raddr1=3 -> rdata1_o=0xDEADBEEF. With re1=0 -> rdata1_o=0.
REQ-027 x0 protection: write x0=0xFFFFFFFF; then read x0 on both ports -> 0x00000000.
REQ-028 Same-cycle bypass: x7=0x11111111; write x7=0x22222222 while reading x7 on both ports. With RF_WB_BYPASS_EN -> 0x22222222 on both ports. Without it -> 0x11111111, then 0x22222222 the next cycle.
REQ-029 Reset mid-operation: write x9=0xA5A5A5A5, then assert rst=0 asynchronously between edges -> rdata immediately 0. After release, read x9 -> 0. A write issued with we_i=1 during reset -> ignored.
REQ-030 Dual-port random: 10k cycles of random writes and reads on both ports, compared against a reference model -> zero mismatches, in both configurations.
